// File: rtl/triplet_frame_packer.sv
// Packs a serial bitstream MSB-first into 3-bit symbols, buffers one frame,
// then bursts the symbols back-to-back on din while count is held high.
module triplet_frame_packer #(
   parameter int MAX_SYM = 16,
   parameter int SYM_W   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_in,
   input  logic       bit_valid,
   input  logic       bit_last,
   output logic       bit_ready,
   output logic       count,
   output logic [2:0] din,
   output logic       frame_done,
   output logic       ovf
);

   localparam int AW = (MAX_SYM > 1) ? $clog2(MAX_SYM) : 1;
   localparam logic [SYM_W-1:0] MAX_CNT = SYM_W'(MAX_SYM);

   typedef enum logic [1:0] {ACCUM, EMIT, GAP} state_t;

   state_t           state_q, state_d;
   logic [SYM_W-1:0] wr_q, wr_d;
   logic [SYM_W-1:0] rd_q, rd_d;
   logic [1:0]       phase_q, phase_d;
   logic [1:0]       sh_q, sh_d;
   logic             bit_ready_q, bit_ready_d;
   logic             count_q, count_d;
   logic [2:0]       din_q, din_d;
   logic             frame_done_q, frame_done_d;
   logic             ovf_q, ovf_d;

   logic [2:0]       sym_mem [MAX_SYM];
   logic             we;
   logic [2:0]       sym;
   logic             accept;

   // bit_ready_q is only ever high while in ACCUM, so it alone qualifies a bit
   assign accept = bit_valid & bit_ready_q;

   // Earliest bit lands in bit2; partial symbols are left-justified, zero-padded
   always_comb begin
      sym = 3'b000;
      unique case (phase_q)
         2'd0:    sym = {bit_in, 2'b00};
         2'd1:    sym = {sh_q[0], bit_in, 1'b0};
         default: sym = {sh_q, bit_in};
      endcase
   end

   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      phase_d      = phase_q;
      sh_d         = sh_q;
      we           = 1'b0;
      count_d      = 1'b0;
      din_d        = 3'b000;
      frame_done_d = 1'b0;
      ovf_d        = 1'b0;

      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               sh_d = {sh_q[0], bit_in};
               if (phase_q == 2'd2 || bit_last) begin
                  phase_d = 2'd0;
                  if (wr_q == MAX_CNT) begin
                     ovf_d = 1'b1;
                     wr_d  = '0;
                  end else begin
                     we   = 1'b1;
                     wr_d = wr_q + 1'b1;
                     if (bit_last) state_d = EMIT;
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         EMIT: begin
            if (rd_q != wr_q) begin
               count_d = 1'b1;
               din_d   = sym_mem[rd_q[AW-1:0]];
               rd_d    = rd_q + 1'b1;
            end else begin
               frame_done_d = 1'b1;
               state_d      = GAP;
            end
         end
         default: begin
            wr_d    = '0;
            rd_d    = '0;
            state_d = ACCUM;
         end
      endcase

      bit_ready_d = (state_d == ACCUM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ACCUM;
         wr_q         <= '0;
         rd_q         <= '0;
         phase_q      <= 2'd0;
         sh_q         <= 2'b00;
         bit_ready_q  <= 1'b0;
         count_q      <= 1'b0;
         din_q        <= 3'b000;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         phase_q      <= phase_d;
         sh_q         <= sh_d;
         bit_ready_q  <= bit_ready_d;
         count_q      <= count_d;
         din_q        <= din_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   // Buffer contents need no reset: wr/rd bound what is ever read
   always_ff @(posedge clk) begin
      if (we) sym_mem[wr_q[AW-1:0]] <= sym;
   end

   assign bit_ready  = bit_ready_q;
   assign count      = count_q;
   assign din        = din_q;
   assign frame_done = frame_done_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_triplet_frame_packer.sv
// Directed bench for triplet_frame_packer: frames, partial symbols, overflow,
// ignored bits during a burst and reset in the middle of a burst.
module tb_triplet_frame_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_last = 1'b0;
   logic       bit_ready;
   logic       count;
   logic [2:0] din;
   logic       frame_done;
   logic       ovf;

   int checks = 0;
   int errors = 0;
   int ovf_seen = 0;
   int count_cycles = 0;
   logic spam = 1'b0;

   logic [2:0] exp_sym [16];
   logic [2:0] t1_syms [14] = '{3'd0, 3'd6, 3'd5, 3'd7, 3'd3, 3'd7, 3'd4,
                                3'd1, 3'd5, 3'd3, 3'd7, 3'd7, 3'd6, 3'd7};

   triplet_frame_packer #(.MAX_SYM(16), .SYM_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .bit_last   (bit_last),
      .bit_ready  (bit_ready),
      .count      (count),
      .din        (din),
      .frame_done (frame_done),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ovf)   ovf_seen++;
      if (count) count_cycles++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bit_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_ready"}, {31'd0, bit_ready}, 32'd1);
   endtask

   task automatic send_bit(input logic b, input logic last);
      bit_valid = 1'b1;
      bit_in    = b;
      bit_last  = last;
      @(posedge clk); #1;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      bit_last  = 1'b0;
   endtask

   task automatic send_syms(input int n);
      logic [2:0] s;
      for (int i = 0; i < n; i++) begin
         s = exp_sym[i];
         for (int b = 2; b >= 0; b--) send_bit(s[b], (i == n - 1) && (b == 0));
      end
   endtask

   // Called right after the edge that accepted bit_last
   task automatic run_burst(input string tag, input int n);
      int len = 0;
      @(posedge clk); #1;
      chk({tag, "_start"}, {31'd0, count}, 32'd1);
      while (count === 1'b1 && len < 20) begin
         if (len < n) chk($sformatf("%s_din%0d", tag, len), {29'd0, din}, {29'd0, exp_sym[len]});
         if (spam) begin
            bit_in   = 1'($urandom);
            bit_last = 1'($urandom);
         end
         len++;
         @(posedge clk); #1;
      end
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      spam      = 1'b0;
      chk({tag, "_len"}, len, n);
      chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
      chk({tag, "_gap_din"}, {29'd0, din}, 32'd0);
      chk({tag, "_gap_rdy"}, {31'd0, bit_ready}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_rdy_back"}, {31'd0, bit_ready}, 32'd1);
      chk({tag, "_done_end"}, {31'd0, frame_done}, 32'd0);
      $display("frame %s: %0d symbols emitted", tag, len);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int o0;
      int c0;

      // Reset state
      #1;
      chk("rst_count", {31'd0, count}, 32'd0);
      chk("rst_din", {29'd0, din}, 32'd0);
      chk("rst_ready", {31'd0, bit_ready}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", {31'd0, bit_ready}, 32'd1);

      // T1: full 14-symbol frame
      for (int i = 0; i < 14; i++) exp_sym[i] = t1_syms[i];
      wait_ready("T1");
      send_syms(14);
      chk("T1_ready_fall", {31'd0, bit_ready}, 32'd0);
      run_burst("T1", 14);

      // T2: partial symbol 1,1,0,1 -> 110, 100
      exp_sym[0] = 3'b110;
      exp_sym[1] = 3'b100;
      wait_ready("T2");
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      run_burst("T2", 2);

      // T3: single bit
      exp_sym[0] = 3'b100;
      wait_ready("T3");
      send_bit(1'b1, 1'b1);
      run_burst("T3", 1);

      // T4: 49 bits overflows on the 17th symbol
      o0 = ovf_seen;
      c0 = count_cycles;
      wait_ready("T4");
      for (int i = 0; i < 49; i++) begin
         if (i == 48) chk("T4_no_early_ovf", ovf_seen, o0);
         send_bit(1'b1, i == 48);
      end
      chk("T4_ovf", {31'd0, ovf}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("T4_ovf_once", ovf_seen, o0 + 1);
      chk("T4_no_count", count_cycles, c0);
      chk("T4_ready", {31'd0, bit_ready}, 32'd1);
      exp_sym[0] = 3'b111;
      send_syms(1);
      run_burst("T4b", 1);
      $display("frame T4: overflow frame dropped");

      // T5: bits offered during the burst are ignored
      c0 = count_cycles;
      exp_sym[0] = 3'b101;
      exp_sym[1] = 3'b010;
      wait_ready("T5");
      send_syms(2);
      bit_valid = 1'b1;
      spam      = 1'b1;
      run_burst("T5", 2);
      exp_sym[0] = 3'b011;
      exp_sym[1] = 3'b110;
      exp_sym[2] = 3'b001;
      send_syms(3);
      run_burst("T5b", 3);
      chk("T5_cycles", count_cycles, c0 + 5);
      chk("T5_no_ovf", ovf_seen, o0 + 1);

      // T6: reset after 5 of 14 symbols
      for (int i = 0; i < 14; i++) exp_sym[i] = t1_syms[i];
      wait_ready("T6");
      send_syms(14);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("T6_pre_din%0d", k), {29'd0, din}, {29'd0, exp_sym[k]});
      end
      rst = 1'b0;
      #1;
      chk("T6_rst_count", {31'd0, count}, 32'd0);
      chk("T6_rst_din", {29'd0, din}, 32'd0);
      chk("T6_rst_ready", {31'd0, bit_ready}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("T6_ready", {31'd0, bit_ready}, 32'd1);
      chk("T6_count_idle", {31'd0, count}, 32'd0);
      exp_sym[0] = 3'b110;
      exp_sym[1] = 3'b100;
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      run_burst("T6b", 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
